debug_bcd_scheduler: RTL and testbench

DEBUG_BCD_SCHEDULER -- requirements
Module: debug_bcd_scheduler

---
 rtl/debug_bcd_scheduler_if.sv | 22 ++
 rtl/debug_bcd_scheduler.sv | 122 ++++++++++++
 tb/tb_debug_bcd_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/debug_bcd_scheduler_if.sv
// Bus bundle for debug_bcd_scheduler.
//   start    : conversion request (master -> slave)
//   seq_in   : packed signed sequences, entry n at [n*SEQ_LEN +: SEQ_LEN]
//   bcd_out  : committed BCD magnitudes, digit d of entry n at [(n*DIGITS+d)*4 +: 4]
//   sign_out : committed sign per entry, 1 = negative
//   busy     : conversion pass in progress
//   done     : one-cycle pulse at pass commit
interface debug_bcd_scheduler_if #(
  parameter int SEQ_LEN = 20,
  parameter int SEQ_NUM = 6,
  parameter int DIGITS  = 6
);
  logic                        start;
  logic [SEQ_LEN*SEQ_NUM-1:0]  seq_in;
  logic [SEQ_NUM*DIGITS*4-1:0] bcd_out;
  logic [SEQ_NUM-1:0]          sign_out;
  logic                        busy;
  logic                        done;

  modport master (output start, seq_in, input bcd_out, sign_out, busy, done);
  modport slave  (input start, seq_in, output bcd_out, sign_out, busy, done);
endinterface

// File: rtl/debug_bcd_scheduler.sv
// Converts SEQ_NUM signed SEQ_LEN-bit debug sequences to sign + BCD magnitude,
// one entry at a time with a bit-serial double-dabble engine.
// Ports:
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : debug_bcd_scheduler_if slave (start, seq_in, bcd_out,
//               sign_out, busy, done)
// Outputs change only on the commit edge, so a pass is never seen half done.
module debug_bcd_scheduler #(
  parameter int SEQ_LEN = 20,
  parameter int SEQ_NUM = 6,
  parameter int DIGITS  = 6
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  debug_bcd_scheduler_if.slave  bus
);
  localparam int IDX_W = (SEQ_NUM > 1) ? $clog2(SEQ_NUM) : 1;
  localparam int CNT_W = $clog2(SEQ_LEN + 1);
  localparam int BCD_W = DIGITS * 4;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

  state_t                      r_state;
  logic [SEQ_LEN*SEQ_NUM-1:0]  r_shadow;
  logic [IDX_W-1:0]            r_idx;
  logic [CNT_W-1:0]            r_cnt;
  logic [SEQ_LEN-1:0]          r_mag;
  logic [BCD_W-1:0]            r_acc;
  logic                        r_sign;
  logic [SEQ_NUM*BCD_W-1:0]    r_work_bcd;
  logic [SEQ_NUM-1:0]          r_work_sign;
  logic [SEQ_NUM*BCD_W-1:0]    r_bcd_out;
  logic [SEQ_NUM-1:0]          r_sign_out;
  logic                        r_busy;
  logic                        r_done;

  logic [SEQ_LEN-1:0]          w_entry;
  logic [BCD_W-1:0]            w_acc_adj;
  logic [SEQ_NUM*BCD_W-1:0]    w_work_bcd_nxt;
  logic [SEQ_NUM-1:0]          w_work_sign_nxt;

  always_comb begin
    w_entry = r_shadow[r_idx*SEQ_LEN +: SEQ_LEN];
    w_acc_adj = r_acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_acc[d*4 +: 4] >= 4'd5)
        w_acc_adj[d*4 +: 4] = r_acc[d*4 +: 4] + 4'd3;
    end
    // Working bank as it will look after the current STORE; the final STORE
    // commits this so the last entry lands on the same edge as the rest.
    w_work_bcd_nxt                         = r_work_bcd;
    w_work_bcd_nxt[r_idx*BCD_W +: BCD_W]   = r_acc;
    w_work_sign_nxt                        = r_work_sign;
    w_work_sign_nxt[r_idx]                 = r_sign;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_mag       <= '0;
      r_acc       <= '0;
      r_sign      <= 1'b0;
      r_work_bcd  <= '0;
      r_work_sign <= '0;
      r_bcd_out   <= '0;
      r_sign_out  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shadow <= bus.seq_in;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_sign  <= w_entry[SEQ_LEN-1];
          // Unsigned SEQ_LEN-bit result: the most negative value maps to
          // 2^(SEQ_LEN-1) with no overflow.
          r_mag   <= w_entry[SEQ_LEN-1] ? (~w_entry + 1'b1) : w_entry;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          {r_acc, r_mag} <= {w_acc_adj, r_mag} << 1;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(SEQ_LEN - 1))
            r_state <= STORE;
        end
        STORE: begin
          r_work_bcd  <= w_work_bcd_nxt;
          r_work_sign <= w_work_sign_nxt;
          if (r_idx == IDX_W'(SEQ_NUM - 1)) begin
            r_bcd_out  <= w_work_bcd_nxt;
            r_sign_out <= w_work_sign_nxt;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= LOAD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bcd_out  = r_bcd_out;
  assign bus.sign_out = r_sign_out;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_debug_bcd_scheduler.sv
// Self-checking bench for debug_bcd_scheduler: directed corner passes,
// mid-pass reset, and randomized passes with noise on start/seq_in during
// the pass, checked against a decimal-arithmetic reference model.
module tb_debug_bcd_scheduler;
  localparam int SL  = 20;
  localparam int SN  = 6;
  localparam int DG  = 6;
  localparam int SW  = SL * SN;
  localparam int BW  = SN * DG * 4;
  localparam int LAT = 1 + 1 + SL + 1 - 1 + (SL + 2) * (SN - 1);  // 132 for defaults
  localparam int N_RAND = 400;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  debug_bcd_scheduler_if #(.SEQ_LEN(SL), .SEQ_NUM(SN), .DIGITS(DG)) bus ();

  debug_bcd_scheduler #(.SEQ_LEN(SL), .SEQ_NUM(SN), .DIGITS(DG)) u_dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed value -> |value| in decimal by division.
  function automatic void model(input logic [SW-1:0] s, output logic [BW-1:0] bcd,
                                output logic [SN-1:0] sg);
    logic signed [SL-1:0] v;
    longint m;
    bcd = '0;
    sg  = '0;
    for (int n = 0; n < SN; n++) begin
      v = s[n*SL +: SL];
      m = longint'(v);
      sg[n] = (m < 0);
      if (m < 0) m = -m;
      for (int d = 0; d < DG; d++) begin
        bcd[(n*DG+d)*4 +: 4] = 4'(m % 10);
        m = m / 10;
      end
    end
  endfunction

  function automatic bit digits_ok(input logic [BW-1:0] bcd);
    digits_ok = 1'b1;
    for (int i = 0; i < SN * DG; i++)
      if (bcd[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
  endfunction

  function automatic logic [SL-1:0] rand_entry();
    case ($urandom_range(0, 7))
      0:       rand_entry = SL'(0);
      1:       rand_entry = {1'b0, {(SL-1){1'b1}}};
      2:       rand_entry = {1'b1, {(SL-1){1'b0}}};
      3:       rand_entry = '1;
      default: rand_entry = SL'($urandom);
    endcase
  endfunction

  function automatic logic [SW-1:0] rand_seq();
    for (int n = 0; n < SN; n++) rand_seq[n*SL +: SL] = rand_entry();
  endfunction

  // Called at a negedge; returns at a negedge one cycle after done.
  task automatic do_pass(input string tag, input logic [SW-1:0] seq, input bit noisy,
                         output logic [BW-1:0] got_bcd);
    logic [BW-1:0] eb, prev_bcd;
    logic [SN-1:0] es, prev_sign;
    int n, busy_cnt;
    bit stable;
    model(seq, eb, es);
    prev_bcd  = bus.bcd_out;
    prev_sign = bus.sign_out;
    bus.seq_in = seq;
    bus.start  = 1'b1;
    @(negedge clk);
    n = 0; busy_cnt = 0; stable = 1'b1;
    while (!bus.done && n < 300) begin
      if (bus.busy) busy_cnt++;
      if (bus.bcd_out !== prev_bcd || bus.sign_out !== prev_sign) stable = 1'b0;
      if (noisy) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.seq_in = rand_seq();
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk_eq({tag, "_latency"}, 256'(n), 256'(LAT));
    chk_eq({tag, "_busy_cycles"}, 256'(busy_cnt), 256'(LAT));
    chk_eq({tag, "_stable"}, 256'(stable), 256'(1));
    chk_eq({tag, "_busy_at_done"}, 256'(bus.busy), 256'(0));
    chk_eq({tag, "_bcd"}, 256'(bus.bcd_out), 256'(eb));
    chk_eq({tag, "_sign"}, 256'(bus.sign_out), 256'(es));
    chk_eq({tag, "_digits"}, 256'(digits_ok(bus.bcd_out)), 256'(1));
    got_bcd = bus.bcd_out;
    @(negedge clk);
    chk_eq({tag, "_done_pulse"}, 256'(bus.done), 256'(0));
  endtask

  initial begin
    logic [SW-1:0] seq;
    logic [BW-1:0] got;
    bit saw_done;
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.start  = 1'b0;
    bus.seq_in = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_bcd",  256'(bus.bcd_out), 256'(0));
    chk_eq("rst_sign", 256'(bus.sign_out), 256'(0));
    chk_eq("rst_busy", 256'(bus.busy), 256'(0));
    chk_eq("rst_done", 256'(bus.done), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    do_pass("zero", '0, 1'b0, got);

    seq = '0;
    seq[0*SL +: SL] = SL'(12345);
    seq[1*SL +: SL] = SL'('h7FFFF);
    seq[2*SL +: SL] = SL'('hFFFFF);
    seq[3*SL +: SL] = SL'('h80000);
    do_pass("corner", seq, 1'b0, got);
    chk_eq("e0_12345",   256'(got[0*DG*4 +: DG*4]), 256'('h012345));
    chk_eq("e1_max",     256'(got[1*DG*4 +: DG*4]), 256'('h524287));
    chk_eq("e2_minus1",  256'(got[2*DG*4 +: DG*4]), 256'('h000001));
    chk_eq("e3_min",     256'(got[3*DG*4 +: DG*4]), 256'('h524288));
    chk_eq("corner_sgn", 256'(bus.sign_out), 256'('b001100));

    do_pass("noisy", rand_seq(), 1'b1, got);

    // Mid-pass reset: no commit, everything cleared, needs a fresh start.
    bus.seq_in = rand_seq();
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    saw_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    chk_eq("mrst_bcd",  256'(bus.bcd_out), 256'(0));
    chk_eq("mrst_sign", 256'(bus.sign_out), 256'(0));
    chk_eq("mrst_busy", 256'(bus.busy), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk_eq("mrst_no_done", 256'(saw_done), 256'(0));
    do_pass("after_rst", rand_seq(), 1'b0, got);

    for (int p = 0; p < N_RAND; p++)
      do_pass("rand", rand_seq(), 1'($urandom_range(0, 1)), got);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
